operand_wakeup_buf: RTL

Parametrised operand wakeup buffer for the Tomasulo back end: holds up to DEPTH pending source operands, each waiting on a ROB tag, and snoops CHANNELS result-broadcast buses every cycle, latching the broadcast value into every slot whose tag matches. Reservation stations and the load/store buffer use it in place of per-entry ad-hoc matching. It adds slot storage, allocation, release and flush, and an optional same-cycle bypass on the read port.

---
 rtl/operand_wakeup_buf.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/operand_wakeup_buf.sv
// Operand wakeup buffer: DEPTH slots wait on ROB tags and capture CDB broadcasts.
// Define WAKEUP_BYPASS_EN to forward a same-cycle broadcast onto the read port.
module operand_wakeup_buf #(
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         alloc_valid,
    input  logic [ROB_ID_W-1:0]          alloc_Q,
    input  logic [DATA_W-1:0]            alloc_V,
    input  logic                         alloc_has_value,
    output logic                         alloc_ready,
    output logic [$clog2(DEPTH)-1:0]     alloc_slot,
    input  logic [CHANNELS-1:0]          cdb_valid,
    input  logic [CHANNELS*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [CHANNELS*DATA_W-1:0]   cdb_value,
    input  logic [$clog2(DEPTH)-1:0]     rd_slot,
    output logic                         rd_busy,
    output logic                         rd_ready,
    output logic [DATA_W-1:0]            rd_V,
    input  logic                         release_valid,
    input  logic [$clog2(DEPTH)-1:0]     release_slot,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full
);

    localparam int SLOT_W = $clog2(DEPTH);
    localparam int CNT_W  = SLOT_W + 1;

`ifdef WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DEPTH-1:0]    ready_q, ready_d;
    logic [ROB_ID_W-1:0] q_q [DEPTH];
    logic [ROB_ID_W-1:0] q_d [DEPTH];
    logic [DATA_W-1:0]   v_q [DEPTH];
    logic [DATA_W-1:0]   v_d [DEPTH];
    logic [CNT_W-1:0]    count_q, count_d;

    logic [ROB_ID_W-1:0] cdb_tag [CHANNELS];
    logic [DATA_W-1:0]   cdb_val [CHANNELS];
    logic [DEPTH-1:0]    hit;
    logic [DATA_W-1:0]   hit_val [DEPTH];
    logic                alloc_hit;
    logic [DATA_W-1:0]   alloc_hit_val;
    logic [SLOT_W-1:0]   free_slot;
    logic                free_found;
    logic                alloc_fire;
    logic                rel_fire;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign cdb_tag[g] = cdb_rob_id[g*ROB_ID_W +: ROB_ID_W];
        assign cdb_val[g] = cdb_value[g*DATA_W +: DATA_W];
    end

    // Ascending scan with first-hit-wins gives the lowest channel priority.
    always_comb begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
            hit[s]     = 1'b0;
            hit_val[s] = '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (!hit[s] && busy_q[s] && !ready_q[s] && cdb_valid[c] && q_q[s] == cdb_tag[c]) begin
                    hit[s]     = 1'b1;
                    hit_val[s] = cdb_val[c];
                end
            end
        end
        alloc_hit     = 1'b0;
        alloc_hit_val = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!alloc_hit && cdb_valid[c] && alloc_Q == cdb_tag[c]) begin
                alloc_hit     = 1'b1;
                alloc_hit_val = cdb_val[c];
            end
        end
    end

    always_comb begin
        free_slot  = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!free_found && !busy_q[i]) begin
                free_slot  = SLOT_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign alloc_ready = free_found;
    assign alloc_slot  = free_slot;
    assign alloc_fire  = rdy && !flush && alloc_valid && free_found;
    assign rel_fire    = rdy && !flush && release_valid && busy_q[release_slot];

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        q_d     = q_q;
        v_d     = v_q;
        count_d = count_q;
        if (rdy) begin
            if (flush) begin
                busy_d  = '0;
                ready_d = '0;
                count_d = '0;
            end else begin
                for (int unsigned s = 0; s < DEPTH; s++) begin
                    if (hit[s]) begin
                        ready_d[s] = 1'b1;
                        v_d[s]     = hit_val[s];
                    end
                end
                // Release is applied after wakeup so a slot freed this cycle stays not-ready.
                if (release_valid) begin
                    busy_d[release_slot]  = 1'b0;
                    ready_d[release_slot] = 1'b0;
                end
                if (alloc_fire) begin
                    busy_d[free_slot]  = 1'b1;
                    q_d[free_slot]     = alloc_Q;
                    ready_d[free_slot] = alloc_has_value || alloc_hit;
                    v_d[free_slot]     = alloc_has_value ? alloc_V : alloc_hit_val;
                end
                count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(rel_fire);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            ready_q <= '0;
            q_q     <= '{default: '0};
            v_q     <= '{default: '0};
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            q_q     <= q_d;
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        rd_busy  = busy_q[rd_slot];
        rd_ready = ready_q[rd_slot];
        rd_V     = ready_q[rd_slot] ? v_q[rd_slot] : '0;
        if (BYPASS && hit[rd_slot]) begin
            rd_ready = 1'b1;
            rd_V     = hit_val[rd_slot];
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule
